// File: rtl/led_line_packer.sv
// led_line_packer: packs PIX_NUM pixels from a FWFT FIFO into one line word with a
// valid/ready handshake and a wrapping row index. Define LED_PACK_LINE_MAX_EN for per-line channel max.
module led_line_packer #(
  parameter int PIX_W   = 24,
  parameter int PIX_NUM = 40,
  parameter int ROW_NUM = 36,
  parameter int ROW_W   = 6
) (
  input  logic                     rd_clk,
  input  logic                     rst_n,
  input  logic                     i_frame_start,
  input  logic                     i_fifo_empty,
  input  logic [PIX_W-1:0]         i_fifo_dout,
  output logic                     o_fifo_rd_en,
  output logic [PIX_W*PIX_NUM-1:0] o_line_data,
  output logic                     o_line_valid,
  input  logic                     i_line_ready,
  output logic [ROW_W-1:0]         o_row_idx,
  output logic                     o_row_last,
  output logic [PIX_W/3-1:0]       o_line_max
);

  localparam int CNT_W = $clog2(PIX_NUM);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_NUM - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_NUM - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_pix_cnt;
  logic [PIX_W*PIX_NUM-1:0] r_line_data;
  logic                     r_line_valid;
  logic                     r_row_last;
  logic [ROW_W-1:0]         r_row_idx;
  logic                     w_accept;
  logic                     w_write;
  logic                     w_last_pix;
  logic                     w_release;

  assign w_accept   = (r_state == FILL) && !i_fifo_empty;
  // A pixel popped in the frame_start cycle belongs to the abandoned line.
  assign w_write    = w_accept && !i_frame_start;
  assign w_last_pix = (r_pix_cnt == LAST_PIX);
  assign w_release  = (r_state == HOLD) && i_line_ready;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = FILL;
      FILL:    if (w_accept && w_last_pix) w_state_nxt = HOLD;
      HOLD:    if (i_line_ready) w_state_nxt = FILL;
      default: w_state_nxt = IDLE;
    endcase
    if (i_frame_start) w_state_nxt = FILL;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
    end else if (i_frame_start) begin
      r_pix_cnt <= '0;
    end else if (w_accept) begin
      r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_data <= '0;
    end else if (w_write) begin
      for (int k = 0; k < PIX_NUM; k++) begin
        if (r_pix_cnt == CNT_W'(k)) r_line_data[k*PIX_W +: PIX_W] <= i_fifo_dout;
      end
    end
  end

  // The row index only moves on leaving HOLD, so row_last can be judged from the current row.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_valid <= 1'b0;
      r_row_last   <= 1'b0;
      r_row_idx    <= '0;
    end else begin
      r_line_valid <= (w_state_nxt == HOLD);
      r_row_last   <= (w_state_nxt == HOLD) && (r_row_idx == LAST_ROW);
      if (i_frame_start) begin
        r_row_idx <= '0;
      end else if (w_release) begin
        r_row_idx <= (r_row_idx == LAST_ROW) ? '0 : r_row_idx + 1'b1;
      end
    end
  end

`ifdef LED_PACK_LINE_MAX_EN
  localparam int CH_W = PIX_W / 3;

  logic [CH_W-1:0] r_acc;
  logic [CH_W-1:0] r_line_max;
  logic [CH_W-1:0] w_pix_max;
  logic [CH_W-1:0] w_acc_nxt;

  // The first pixel of a line seeds the accumulator, discarding any earlier line's value.
  always_comb begin
    w_pix_max = i_fifo_dout[0 +: CH_W];
    if (i_fifo_dout[CH_W +: CH_W] > w_pix_max) w_pix_max = i_fifo_dout[CH_W +: CH_W];
    if (i_fifo_dout[2*CH_W +: CH_W] > w_pix_max) w_pix_max = i_fifo_dout[2*CH_W +: CH_W];
    w_acc_nxt = w_pix_max;
    if ((r_pix_cnt != '0) && (r_acc > w_pix_max)) w_acc_nxt = r_acc;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_line_max <= '0;
    end else if (i_frame_start) begin
      r_acc <= '0;
    end else if (w_write) begin
      r_acc <= w_acc_nxt;
      if (w_last_pix) r_line_max <= w_acc_nxt;
    end
  end

  assign o_line_max = r_line_max;
`else
  assign o_line_max = '0;
`endif

  assign o_fifo_rd_en = w_accept;
  assign o_line_data  = r_line_data;
  assign o_line_valid = r_line_valid;
  assign o_row_idx    = r_row_idx;
  assign o_row_last   = r_row_last;

endmodule

// File: doc/led_line_packer.md
# led_line_packer

Parametrised successor to the fixed 40-pixel, 24-bit line packer in the FIFO-to-LED path. It pops pixels from a first-word-fall-through FIFO and packs PIX_NUM pixels of PIX_W bits into one wide line word. It presents each line with a valid/ready handshake and a row index that wraps at ROW_NUM. It sits between the backlight-block FIFO and the LED driver serialiser, in the rd_clk domain.

## Interface
- PIX_W, 24, bits per pixel; must be a multiple of 3 (three channels of CH_W = PIX_W/3 bits)
- PIX_NUM, 40, pixels per line word (≥2)
- ROW_NUM, 36, rows per frame (≥2)
- ROW_W, 6, row index width; 2^ROW_W ≥ ROW_NUM
- rd_clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  synchronous single-cycle pulse; restarts packing at row 0
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  PIX_W  FWFT FIFO head word; valid whenever fifo_empty=0
- fifo_rd_en  out  1  pop strobe
- line_data  out  PIX_W*PIX_NUM  packed line; pixel k in bits [k*PIX_W +: PIX_W]
- line_valid  out  1  line_data, row_idx, row_last and line_max are valid
- line_ready  in  1  downstream accepts the line
- row_idx  out  ROW_W  row of the current or presented line
- row_last  out  1  line_valid && row_idx==ROW_NUM-1
- line_max  out  CH_W  maximum channel value over the presented line (see Configuration)

## Operation
- States: IDLE, FILL, HOLD. Reset enters IDLE. IDLE always goes to FILL on the next cycle.
- fifo_rd_en = (state==FILL) && !fifo_empty. This is combinational, never asserted on an empty FIFO, and never asserted outside FILL.
- Accept: a cycle with fifo_rd_en=1. fifo_dout is written to slot pix_cnt, and pix_cnt increments.
- pix_cnt ranges 0..PIX_NUM-1, with width $clog2(PIX_NUM).
  - An accept at pix_cnt=PIX_NUM-1 clears pix_cnt, moves to HOLD, and sets line_valid=1 on the next cycle.
- Slots not yet rewritten keep their previous-line values. line_data is never cleared except by reset.
- HOLD:
  - line_data is frozen and line_valid is held high.
  - When line_ready=1, line_valid drops next cycle and the block returns to FILL.
  - row_idx increments at the same time, wrapping from ROW_NUM-1 to 0.
- line_ready is ignored outside HOLD.
- frame_start has the highest priority in any state. Next cycle:
  - state=FILL, pix_cnt=0, row_idx=0, line_valid=0.
  - line_data is unchanged, and any partial or unaccepted line is discarded.
- An accept coincident with frame_start is still popped from the FIFO, but its data is discarded.
- A frame_start coincident with a HOLD handshake: frame_start wins, and row_idx becomes 0, not +1.
- An empty FIFO mid-line stalls FILL indefinitely with no timeout. pix_cnt and line_data hold their values.

## Timing
- Reset values:
  - fifo_rd_en=0, line_data=0, line_valid=0, row_idx=0, row_last=0, line_max=0.
  - Internal: state=IDLE, pix_cnt=0.
- The first accept is possible 1 cycle after reset release (IDLE to FILL).
- Latency: line_valid rises 1 cycle after the accept of pixel PIX_NUM-1.
- Throughput: with a non-empty FIFO and line_ready tied high, one line takes PIX_NUM+1 cycles (PIX_NUM accepts + 1 HOLD cycle).
- All outputs except fifo_rd_en are registered.

## Configuration
- LED_PACK_LINE_MAX_EN defined:
  - A running max of the three CH_W channels of every accepted pixel is kept in the line's accumulator.
  - The line's first accept loads max(ch0,ch1,ch2) into the accumulator; subsequent accepts take the max against the accumulator.
  - line_max is registered at the last accept, so it is valid with line_valid and stable through HOLD.
  - frame_start clears the accumulator.
- Not defined: the line_max port exists, is tied to 0, and has no max logic.

## Test plan
- Reset, then FIFO preloaded with pixels 24'h000001..24'h000028, line_ready=1:
  - fifo_rd_en high for 40 cycles.
  - line_valid pulses 1 cycle.
  - line_data[23:0]=24'h000001 and line_data[959:936]=24'h000028.
  - row_idx=0.
- Backpressure: line_ready=0 for 10 cycles after line_valid:
  - line_data and line_valid are held.
  - fifo_rd_en=0 throughout.
  - On line_ready=1, line_valid drops next cycle and row_idx becomes 1.
- 36 consecutive lines:
  - row_last=1 only on line 35.
  - row_idx wraps to 0 after line 35 is accepted.
- Mid-line empty: FIFO empties after 17 pixels, then refills 5 cycles later:
  - No pops while empty.
  - The line completes with pixels in order 0..39.
- frame_start at pix_cnt=20 of row 3:
  - Next cycle row_idx=0 and pix_cnt=0.
  - The next 40 pops form row 0.
  - frame_start with a simultaneous HOLD handshake gives row_idx=0.
- With LED_PACK_LINE_MAX_EN defined, pixel 12 = 24'h00C800 and all others ≤ 8'h10:
  - line_max=8'hC8.
  - The following line (all channels 8'h05) gives line_max=8'h05.
